// File: rtl/eth_log_axis_arbiter.sv
// -----------------------------------------------------------------------------
// eth_log_axis_arbiter
// Packet-granular round-robin arbiter that merges C_NUM_INPUTS AXI-Stream log
// sources onto one shared log stream. A grant is taken in IDLE and held until
// the granted source's tlast beat is accepted, so packets never interleave.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_axis_log_tdata      packed slave data, stream i at [i*W +: W]
//   s_axis_log_tlast      per-stream last beat
//   s_axis_log_tvalid     per-stream valid
//   s_axis_log_tready     per-stream ready (only the granted stream, while BUSY)
//   m_axis_log_tdata      muxed data (zero outside BUSY)
//   m_axis_log_tid        index of the current/last granted stream
//   m_axis_log_tlast      muxed last (zero outside BUSY)
//   m_axis_log_tvalid     muxed valid (zero outside BUSY)
//   m_axis_log_tready     sink ready
//   packet_count          per-stream forwarded-packet counters, 32 bits each
//
// Optional feature: define ETH_LOG_AXIS_ARBITER_STATS_EN to build the
// per-stream packet counters; otherwise packet_count is tied to zero.
// -----------------------------------------------------------------------------
module eth_log_axis_arbiter #(
   parameter int unsigned C_NUM_INPUTS     = 4,
   parameter int unsigned C_AXIS_LOG_WIDTH = 64,
   parameter int unsigned C_SEL_WIDTH      = $clog2(C_NUM_INPUTS)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [C_NUM_INPUTS*C_AXIS_LOG_WIDTH-1:0] s_axis_log_tdata,
   input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tlast,
   input  logic [C_NUM_INPUTS-1:0]                  s_axis_log_tvalid,
   output logic [C_NUM_INPUTS-1:0]                  s_axis_log_tready,
   output logic [C_AXIS_LOG_WIDTH-1:0]              m_axis_log_tdata,
   output logic [C_SEL_WIDTH-1:0]                   m_axis_log_tid,
   output logic                                     m_axis_log_tlast,
   output logic                                     m_axis_log_tvalid,
   input  logic                                     m_axis_log_tready,
   output logic [C_NUM_INPUTS*32-1:0]               packet_count
);

   localparam int unsigned CNT_WIDTH = 32;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                  state;
   logic [C_SEL_WIDTH-1:0]  grant;
   logic [C_SEL_WIDTH-1:0]  rr_ptr;

   logic                    req_any_c;
   logic [C_SEL_WIDTH-1:0]  next_grant_c;
   int                      srch_idx_c;
   logic                    last_xfer_c;

   // Rotating-priority search: first requester at rr_ptr, rr_ptr+1, ... mod N.
   // Walk from the farthest slot down so the nearest requester wins.
   always_comb begin
      req_any_c    = 1'b0;
      next_grant_c = '0;
      srch_idx_c   = 0;
      for (int k = int'(C_NUM_INPUTS) - 1; k >= 0; k--) begin
         srch_idx_c = int'(rr_ptr) + k;
         if (srch_idx_c >= int'(C_NUM_INPUTS)) begin
            srch_idx_c = srch_idx_c - int'(C_NUM_INPUTS);
         end
         if (s_axis_log_tvalid[C_SEL_WIDTH'(srch_idx_c)]) begin
            req_any_c    = 1'b1;
            next_grant_c = C_SEL_WIDTH'(srch_idx_c);
         end
      end
   end

   // Data path mux: only the granted stream is visible, and only while BUSY.
   always_comb begin
      m_axis_log_tdata  = '0;
      m_axis_log_tlast  = 1'b0;
      m_axis_log_tvalid = 1'b0;
      s_axis_log_tready = '0;
      m_axis_log_tid    = grant;
      if (state == BUSY) begin
         for (int i = 0; i < int'(C_NUM_INPUTS); i++) begin
            if (grant == C_SEL_WIDTH'(i)) begin
               m_axis_log_tdata     = s_axis_log_tdata[i*C_AXIS_LOG_WIDTH +: C_AXIS_LOG_WIDTH];
               m_axis_log_tlast     = s_axis_log_tlast[i];
               m_axis_log_tvalid    = s_axis_log_tvalid[i];
               s_axis_log_tready[i] = m_axis_log_tready;
            end
         end
      end
   end

   // Accepted tlast beat of the granted packet ends the grant.
   assign last_xfer_c = (state == BUSY) && m_axis_log_tvalid && m_axis_log_tready &&
                        m_axis_log_tlast;

   // Arbitration FSM. Grant only moves in IDLE, which keeps the mux stable
   // through sink backpressure and source stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_any_c) begin
                  grant <= next_grant_c;
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (last_xfer_c) begin
                  state <= IDLE;
                  // Explicit wrap so non-power-of-two input counts stay in range.
                  if (grant == C_SEL_WIDTH'(C_NUM_INPUTS - 1)) begin
                     rr_ptr <= '0;
                  end else begin
                     rr_ptr <= grant + C_SEL_WIDTH'(1);
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef ETH_LOG_AXIS_ARBITER_STATS_EN
   logic [C_NUM_INPUTS-1:0][CNT_WIDTH-1:0] pkt_cnt;

   // Per-stream forwarded-packet counters; free-running wrap at 2^32.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pkt_cnt <= '0;
      end else if (last_xfer_c) begin
         for (int i = 0; i < int'(C_NUM_INPUTS); i++) begin
            if (grant == C_SEL_WIDTH'(i)) begin
               pkt_cnt[i] <= pkt_cnt[i] + CNT_WIDTH'(1);
            end
         end
      end
   end

   assign packet_count = pkt_cnt;
`else
   assign packet_count = '0;
`endif

endmodule

// File: tb/tb_eth_log_axis_arbiter.sv
// -----------------------------------------------------------------------------
// tb_eth_log_axis_arbiter
// Directed bench for eth_log_axis_arbiter: a 4-input instance for the main
// scenarios and a 3-input instance for the non-power-of-two round-robin wrap.
// A small per-stream packet source model drives the slave streams; expected
// beat order, timing and ids are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_eth_log_axis_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned W  = 64;
   localparam int unsigned S  = 2;
   localparam int unsigned N3 = 3;
   localparam int unsigned W3 = 16;

   logic clk = 1'b0;
   logic rst_n;

   logic [N*W-1:0]   s_tdata;
   logic [N-1:0]     s_tlast;
   logic [N-1:0]     s_tvalid;
   logic [N-1:0]     s_tready;
   logic [W-1:0]     m_tdata;
   logic [S-1:0]     m_tid;
   logic             m_tlast;
   logic             m_tvalid;
   logic             m_tready;
   logic [N*32-1:0]  packet_count;

   logic [N3*W3-1:0] s3_tdata;
   logic [N3-1:0]    s3_tlast;
   logic [N3-1:0]    s3_tvalid;
   logic [N3-1:0]    s3_tready;
   logic [W3-1:0]    m3_tdata;
   logic [1:0]       m3_tid;
   logic             m3_tlast;
   logic             m3_tvalid;
   logic             m3_tready;
   logic [N3*32-1:0] packet_count3;

   eth_log_axis_arbiter #(.C_NUM_INPUTS(N), .C_AXIS_LOG_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_log_tdata(s_tdata), .s_axis_log_tlast(s_tlast),
      .s_axis_log_tvalid(s_tvalid), .s_axis_log_tready(s_tready),
      .m_axis_log_tdata(m_tdata), .m_axis_log_tid(m_tid),
      .m_axis_log_tlast(m_tlast), .m_axis_log_tvalid(m_tvalid),
      .m_axis_log_tready(m_tready), .packet_count(packet_count)
   );

   eth_log_axis_arbiter #(.C_NUM_INPUTS(N3), .C_AXIS_LOG_WIDTH(W3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .s_axis_log_tdata(s3_tdata), .s_axis_log_tlast(s3_tlast),
      .s_axis_log_tvalid(s3_tvalid), .s_axis_log_tready(s3_tready),
      .m_axis_log_tdata(m3_tdata), .m_axis_log_tid(m3_tid),
      .m_axis_log_tlast(m3_tlast), .m_axis_log_tvalid(m3_tvalid),
      .m_axis_log_tready(m3_tready), .packet_count(packet_count3)
   );

   always #5 clk = ~clk;

   // Source model state and transfer log.
   int         pkts[N];
   int         plen[N];
   int         beat[N];
   bit         stall[N];
   bit         sink_rdy;
   bit         rst_req;
   bit         d3_on;
   int         cyc;
   int         log_n;
   int         log_cyc[64];
   logic [S-1:0] log_tid[64];
   logic [W-1:0] log_data[64];
   logic       log_last[64];
   int         d3_n;
   logic [1:0] d3_tid[16];
   logic [W3-1:0] d3_data[16];
   logic       d3_last[16];
   int         other_rdy_err;
   int         n_pass;
   int         n_total;

   function automatic logic [W-1:0] data_of(input int i, input int b);
      return {16'(i), 48'((b + 1) * 32'h1111)};
   endfunction

   function automatic bit busy_src();
      bit r = 1'b0;
      for (int i = 0; i < N; i++) if (pkts[i] > 0) r = 1'b1;
      return r;
   endfunction

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         pkts[i] = 0; plen[i] = 1; beat[i] = 0; stall[i] = 1'b0;
      end
   endtask

   task automatic clear_log();
      cyc = 0; log_n = 0; other_rdy_err = 0;
   endtask

   task automatic load(input int i, input int n, input int len);
      pkts[i] = n; plen[i] = len; beat[i] = 0;
   endtask

   // One clock: drive inputs after the edge, sample mid-cycle, advance model.
   task automatic run_cycle();
      @(posedge clk);
      #1;
      rst_n = !rst_req;
      for (int i = 0; i < N; i++) begin
         s_tvalid[i] = (pkts[i] > 0) && !stall[i];
         s_tlast[i]  = (beat[i] == plen[i] - 1);
         s_tdata[i*W +: W] = data_of(i, beat[i]);
      end
      m_tready  = sink_rdy;
      s3_tvalid = {N3{d3_on}};
      #1;
      if (rst_n && m_tvalid && m_tready) begin
         if (log_n < 64) begin
            log_cyc[log_n] = cyc; log_tid[log_n] = m_tid;
            log_data[log_n] = m_tdata; log_last[log_n] = m_tlast;
         end
         log_n++;
      end
      if (rst_n && ((s_tready & ~(4'b0001 << m_tid)) != 4'b0000)) other_rdy_err++;
      for (int i = 0; i < N; i++) begin
         if (rst_n && s_tvalid[i] && s_tready[i]) begin
            if (s_tlast[i]) begin beat[i] = 0; pkts[i]--; end
            else beat[i]++;
         end
      end
      if (rst_n && m3_tvalid && m3_tready) begin
         if (d3_n < 16) begin
            d3_tid[d3_n] = m3_tid; d3_data[d3_n] = m3_tdata; d3_last[d3_n] = m3_tlast;
         end
         d3_n++;
      end
      cyc++;
   endtask

   task automatic run_until_done(input int max_cyc);
      int t = 0;
      while (busy_src() && t < max_cyc) begin
         run_cycle();
         t++;
      end
      n_total++;
      if (busy_src()) $display("FAIL drain_timeout: sources still pending after %0d cycles", t);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; rst_req = 1'b0; sink_rdy = 1'b0; d3_on = 1'b0;
      s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b0;
      s3_tdata = {16'hC2C2, 16'hC1C1, 16'hC0C0}; s3_tlast = '1; s3_tvalid = '0;
      m3_tready = 1'b1;
      clear_src(); clear_log(); d3_n = 0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (s_tready !== 4'b0000) $display("FAIL rst_tready: got %b want 0000", s_tready); else n_pass++;
      n_total++; if (m_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", m_tvalid); else n_pass++;
      n_total++; if (m_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", m_tlast); else n_pass++;
      n_total++; if (m_tdata !== 64'h0) $display("FAIL rst_tdata: got %h want 0", m_tdata); else n_pass++;
      n_total++; if (m_tid !== 2'd0) $display("FAIL rst_tid: got %0d want 0", m_tid); else n_pass++;
      n_total++; if (packet_count !== 128'h0) $display("FAIL rst_pkt_cnt: got %h want 0", packet_count); else n_pass++;
      n_total++; if (m3_tvalid !== 1'b0 || packet_count3 !== 96'h0)
         $display("FAIL rst_dut3: tvalid %b cnt %h want 0/0", m3_tvalid, packet_count3); else n_pass++;
   endtask

   task automatic test_simultaneous();
      int exp_tid;
      int exp_cyc;
      clear_src(); clear_log(); sink_rdy = 1'b1;
      load(0, 1, 6); load(2, 1, 6); load(3, 1, 6);
      run_until_done(60);
      n_total++; if (log_n !== 18) $display("FAIL sim_beats: got %0d want 18", log_n); else n_pass++;
      for (int k = 0; k < 18 && k < log_n; k++) begin
         exp_tid = (k < 6) ? 0 : ((k < 12) ? 2 : 3);
         exp_cyc = 1 + (k / 6) * 7 + (k % 6);
         n_total++;
         if (log_tid[k] !== 2'(exp_tid) || log_data[k] !== data_of(exp_tid, k % 6) ||
             log_last[k] !== (k % 6 == 5) || log_cyc[k] !== exp_cyc)
            $display("FAIL sim_beat%0d: got tid %0d data %h last %b cyc %0d want tid %0d data %h last %b cyc %0d",
                     k, log_tid[k], log_data[k], log_last[k], log_cyc[k],
                     exp_tid, data_of(exp_tid, k % 6), (k % 6 == 5), exp_cyc);
         else n_pass++;
      end
      n_total++; if (other_rdy_err !== 0) $display("FAIL sim_other_rdy: got %0d want 0", other_rdy_err); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [N-1:0] exp_rdy;
      clear_src(); clear_log();
      load(2, 1, 6);
      for (int t = 0; t < 20 && busy_src(); t++) begin
         sink_rdy = (t % 2 == 1);
         run_cycle();
         exp_rdy = (t == 0) ? 4'b0000 : (sink_rdy ? 4'b0100 : 4'b0000);
         n_total++;
         if (s_tready !== exp_rdy) $display("FAIL bp_tready_t%0d: got %b want %b", t, s_tready, exp_rdy);
         else n_pass++;
      end
      sink_rdy = 1'b1;
      n_total++; if (log_n !== 6) $display("FAIL bp_beats: got %0d want 6", log_n); else n_pass++;
      for (int k = 0; k < 6 && k < log_n; k++) begin
         n_total++;
         if (log_tid[k] !== 2'd2 || log_data[k] !== data_of(2, k) ||
             log_last[k] !== (k == 5) || log_cyc[k] !== 1 + 2 * k)
            $display("FAIL bp_beat%0d: got tid %0d data %h cyc %0d want tid 2 data %h cyc %0d",
                     k, log_tid[k], log_data[k], log_cyc[k], data_of(2, k), 1 + 2 * k);
         else n_pass++;
      end
   endtask

   task automatic test_source_stall();
      int exp_tid;
      int exp_cyc;
      clear_src(); clear_log(); sink_rdy = 1'b1;
      load(1, 1, 6);
      for (int t = 0; t < 40 && busy_src(); t++) begin
         if (t == 1) load(0, 1, 6);
         stall[1] = (t >= 3 && t <= 6);
         run_cycle();
         if (t >= 3 && t <= 6) begin
            n_total++;
            if (m_tvalid !== 1'b0 || m_tid !== 2'd1 || s_tready !== 4'b0010)
               $display("FAIL stall_t%0d: got tvalid %b tid %0d tready %b want 0 1 0010",
                        t, m_tvalid, m_tid, s_tready);
            else n_pass++;
         end
      end
      n_total++; if (log_n !== 12) $display("FAIL stall_beats: got %0d want 12", log_n); else n_pass++;
      for (int k = 0; k < 12 && k < log_n; k++) begin
         exp_tid = (k < 6) ? 1 : 0;
         exp_cyc = (k < 2) ? 1 + k : ((k < 6) ? 5 + k : 6 + k);
         n_total++;
         if (log_tid[k] !== 2'(exp_tid) || log_data[k] !== data_of(exp_tid, k % 6) ||
             log_cyc[k] !== exp_cyc)
            $display("FAIL stall_beat%0d: got tid %0d data %h cyc %0d want tid %0d data %h cyc %0d",
                     k, log_tid[k], log_data[k], log_cyc[k], exp_tid, data_of(exp_tid, k % 6), exp_cyc);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_packet();
      clear_src(); clear_log(); sink_rdy = 1'b1;
      load(2, 1, 1);
      run_until_done(10);
      clear_log();
      load(1, 1, 6);
      for (int t = 0; t < 4; t++) run_cycle();
      rst_req = 1'b1;
      run_cycle();
      rst_req = 1'b0;
      clear_src();
      load(1, 1, 2); load(3, 1, 2);
      run_cycle();
      n_total++; if (s_tready !== 4'b0000) $display("FAIL rmid_tready: got %b want 0000", s_tready); else n_pass++;
      n_total++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 64'h0)
         $display("FAIL rmid_master: got tvalid %b tlast %b tdata %h want 0", m_tvalid, m_tlast, m_tdata); else n_pass++;
      n_total++; if (m_tid !== 2'd0) $display("FAIL rmid_tid: got %0d want 0", m_tid); else n_pass++;
      n_total++; if (packet_count !== 128'h0) $display("FAIL rmid_pkt_cnt: got %h want 0", packet_count); else n_pass++;
      n_total++; if (log_n !== 3) $display("FAIL rmid_partial_beats: got %0d want 3", log_n); else n_pass++;
      run_cycle();
      n_total++; if (m_tid !== 2'd1 || m_tvalid !== 1'b1)
         $display("FAIL rmid_regrant: got tid %0d tvalid %b want 1 1", m_tid, m_tvalid); else n_pass++;
      run_until_done(20);
   endtask

   task automatic test_rr_wrap();
      clear_src(); d3_n = 0; d3_on = 1'b1;
      for (int t = 0; t < 40 && d3_n < 6; t++) run_cycle();
      d3_on = 1'b0;
      n_total++; if (d3_n < 6) $display("FAIL rr3_count: got %0d want 6", d3_n); else n_pass++;
      for (int k = 0; k < 6 && k < d3_n; k++) begin
         n_total++;
         if (d3_tid[k] !== 2'(k % 3) || d3_data[k] !== {2{8'hC0 | 8'(k % 3)}} || d3_last[k] !== 1'b1)
            $display("FAIL rr3_grant%0d: got tid %0d data %h last %b want tid %0d", k,
                     d3_tid[k], d3_data[k], d3_last[k], k % 3);
         else n_pass++;
      end
      run_cycle();
   endtask

   task automatic test_stats();
      int exp_tid[17] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3};
      int exp_cyc[17] = '{1, 2, 3, 4, 5, 6, 8, 10, 11, 12, 13, 14, 15, 17, 19, 21, 23};
      logic [31:0] exp_cnt[N];
      clear_src(); sink_rdy = 1'b1;
      rst_req = 1'b1;
      run_cycle();
      run_cycle();
      rst_req = 1'b0;
      clear_log();
      load(3, 5, 1); load(0, 2, 6);
      run_until_done(80);
      run_cycle();
      n_total++; if (log_n !== 17) $display("FAIL stats_beats: got %0d want 17", log_n); else n_pass++;
      for (int k = 0; k < 17 && k < log_n; k++) begin
         n_total++;
         if (log_tid[k] !== 2'(exp_tid[k]) || log_cyc[k] !== exp_cyc[k])
            $display("FAIL b2b_beat%0d: got tid %0d cyc %0d want tid %0d cyc %0d",
                     k, log_tid[k], log_cyc[k], exp_tid[k], exp_cyc[k]);
         else n_pass++;
      end
`ifdef ETH_LOG_AXIS_ARBITER_STATS_EN
      exp_cnt[0] = 32'd2; exp_cnt[1] = 32'd0; exp_cnt[2] = 32'd0; exp_cnt[3] = 32'd5;
`else
      exp_cnt[0] = 32'd0; exp_cnt[1] = 32'd0; exp_cnt[2] = 32'd0; exp_cnt[3] = 32'd0;
`endif
      for (int i = 0; i < N; i++) begin
         n_total++;
         if (packet_count[i*32 +: 32] !== exp_cnt[i])
            $display("FAIL stats_cnt%0d: got %0d want %0d", i, packet_count[i*32 +: 32], exp_cnt[i]);
         else n_pass++;
      end
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      test_reset();
      test_simultaneous();
      test_backpressure();
      test_source_stall();
      test_reset_mid_packet();
      test_rr_wrap();
      test_stats();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/eth_log_axis_arbiter.md
Name: eth_log_axis_arbiter

Overview:
Shares one M_AXIS_LOG output between C_NUM_INPUTS log sources (latency measurers, stats collectors, frame detectors), each emitting complete log packets on its own AXIS log stream. Packet-granular round-robin arbiter: a grant is held from a packet's first beat until its tlast beat is accepted, so packets are never interleaved. Sits between the per-core log ports and the shared DMA/FIFO log sink.

Parameters:
C_NUM_INPUTS, 4, number of slave log streams; legal range 2..8
C_AXIS_LOG_WIDTH, 64, tdata width of every slave stream and of the master stream
C_SEL_WIDTH, $clog2(C_NUM_INPUTS), derived; width of grant index and m_axis_log_tid

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_axis_log_tdata  in  C_NUM_INPUTS*C_AXIS_LOG_WIDTH  packed slave data; stream i at [i*W +: W]
s_axis_log_tlast  in  C_NUM_INPUTS  per-stream last beat
s_axis_log_tvalid  in  C_NUM_INPUTS  per-stream valid
s_axis_log_tready  out  C_NUM_INPUTS  per-stream ready
m_axis_log_tdata  out  C_AXIS_LOG_WIDTH  muxed data
m_axis_log_tid  out  C_SEL_WIDTH  index of granted stream
m_axis_log_tlast  out  1  muxed last
m_axis_log_tvalid  out  1  muxed valid
m_axis_log_tready  in  1  sink ready
packet_count  out  C_NUM_INPUTS*32  per-stream forwarded-packet counters (see Optional Feature)

Behaviour:
- Reset: state=IDLE, grant=0, rr_ptr=0, all s_axis_log_tready=0, m_axis_log_tvalid=0, m_axis_log_tlast=0, m_axis_log_tdata=0, m_axis_log_tid=0, packet_count=0.
- States: IDLE, BUSY.
- IDLE: all tready=0, m_tvalid=0. If any s_tvalid: grant <= first i with s_tvalid[i] searching rr_ptr, rr_ptr+1, ... modulo C_NUM_INPUTS; state <= BUSY. Otherwise hold.
- Arbitration latency: one cycle; a request seen in IDLE at cycle n can transfer its first beat at n+1 at the earliest.
- BUSY: combinational mux: m_tdata=s_tdata[grant], m_tlast=s_tlast[grant], m_tvalid=s_tvalid[grant], m_tid=grant; s_tready[grant]=m_tready; all other tready=0. Outputs other than m_tid are zero when not BUSY.
- Beat transfer = m_tvalid & m_tready. On a transfer with m_tlast=1: state <= IDLE, rr_ptr <= (grant+1) mod C_NUM_INPUTS (explicit wrap, not power-of-2 overflow when C_NUM_INPUTS is not a power of two).
- Packet end is defined solely by tlast; no beat count is assumed (384-bit packets at W=64 are 6 beats, but any length ≥1 is legal, including 1-beat packets).
- Granted source dropping tvalid mid-packet: grant held, m_tvalid=0, no other source served until its tlast transfer.
- m_tready low: everything held; the data mux is stable because grant only changes in IDLE.
- Back-to-back packets: one IDLE bubble cycle between consecutive packets, including from the same source.
- Single active source: re-granted every packet; fairness ensures each pending source waits at most C_NUM_INPUTS-1 packets.
- Non-granted sources requesting: tready stays 0; their tvalid/tdata must be held (AXIS rule); the arbiter never drops data.
- rst_n low mid-packet: immediate return to reset values on the next edge; the partial packet is abandoned and the sink must tolerate the truncated packet.

Optional Feature:
Macro ETH_LOG_AXIS_ARBITER_STATS_EN.
- Defined: packet_count[i*32 +: 32] increments by 1 on each tlast transfer from stream i; wraps 0xFFFFFFFF -> 0; cleared only by reset.
- Not defined: packet_count tied to 0, no counter registers; arbitration unaffected.

Test Plan:
- Reset mid-packet: stream 1 sends 3 of 6 beats, rst_n=0 one cycle -> all tready=0, m_tvalid=0, packet_count=0; after release, the next grant goes to the lowest-index requester starting at 0.
- Simultaneous requests: streams 0,2,3 each hold a 6-beat packet, m_tready=1 -> output order 0,2,3, tid matches, 6 beats each, exactly 1 idle cycle between packets; 20 cycles total from first request.
- Round-robin wrap with C_NUM_INPUTS=3: all streams request continuously -> grant sequence 0,1,2,0,1,2; rr_ptr wraps 2->0.
- Backpressure: m_tready toggles 1,0,1,0 during stream 2 packet with data 0x1111..0x6666 -> output beats identical and in order, stream 2 tready mirrors m_tready, other tready=0 throughout.
- Source stall: granted stream 1 deasserts tvalid for 4 cycles after beat 2 while stream 0 requests -> m_tvalid=0 for those 4 cycles, stream 0 is not granted until stream 1's tlast is accepted.
- Stats (macro defined): stream 3 sends 5 packets of 1 beat, stream 0 sends 2 packets of 6 beats -> packet_count = {5,0,0,2} for streams {3,2,1,0}; with macro undefined -> all zero.
